// File: rtl/up_counter_ctrl.sv
// Sequencing controller for a free-running up counter: start/stop/resume/clear
// command handling, programmable prescaler and terminal count, one-shot or periodic.
module up_counter_ctrl #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_resume,
  input  logic             cmd_clear,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_periodic,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             periodic_q, periodic_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             advance;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      limit_q    <= '0;
      pre_q      <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      pre_q      <= pre_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    pre_d      = pre_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    advance    = 1'b0;

    if (cmd_clear) begin
      state_d = StIdle;
      count_d = '0;
      pre_d   = '0;
    end else if (cmd_start) begin
      state_d    = StRun;
      count_d    = '0;
      pre_d      = '0;
      limit_d    = cfg_limit;
      prescale_d = cfg_prescale;
      periodic_d = cfg_periodic;
    end else begin
      unique case (state_q)
        StRun: begin
          // A stop in a would-be tick cycle freezes everything, tick included.
          if (cmd_stop) state_d = StPause;
          else          advance = 1'b1;
        end
        StPause: begin
          // The resume cycle already counts as a running cycle for the prescaler.
          if (cmd_resume) begin
            state_d = StRun;
            advance = 1'b1;
          end
        end
        default: ;
      endcase

      if (advance) begin
        if (pre_q == prescale_q) begin
          pre_d  = '0;
          tick_d = 1'b1;
          if (count_q == limit_q) begin
            done_d = 1'b1;
            if (periodic_q) count_d = '0;
            else            state_d = StDone;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    count = count_q;
    tick  = tick_q;
    done  = done_q;
    busy  = (state_q == StRun) || (state_q == StPause);
    state = state_q;
  end

endmodule
